// File: rtl/pipe_out_block_ctrl.sv
// Pipe-out block controller: bridges a block-ready FWFT FIFO to a host block-throttled
// pipe-out endpoint, enforcing exact BLOCK_LEN-word transfers and flagging faults.
module pipe_out_block_ctrl #(
  parameter int BLOCK_LEN = 1024,
  parameter int TIMEOUT   = 65535,
  parameter int CNT_W     = 11
) (
  input  logic        rd_clk,
  input  logic        rst,
  input  logic        fifo_rd_ready,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        ep_ready,
  input  logic        ep_blockstrobe,
  input  logic        ep_read,
  output logic [15:0] ep_datain,
  input  logic        err_clr,
  output logic [15:0] block_count,
  output logic        underrun,
  output logic        timeout_err,
  output logic        proto_err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_XFER,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    word_cnt, word_cnt_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic                ep_ready_nxt;

  logic in_xfer;
  logic last_word;
  logic stall_limit;
  logic block_done;
  logic underrun_set;
  logic timeout_set;
  logic proto_set;

  assign in_xfer     = (state == S_XFER);
  assign last_word   = (word_cnt == CNT_W'(BLOCK_LEN - 1));
  assign stall_limit = (idle_cnt == IDLE_W'(TIMEOUT - 1));

  assign block_done   = in_xfer & ep_read & last_word;
  assign timeout_set  = in_xfer & ~ep_read & stall_limit;
  assign underrun_set = in_xfer & ep_read & fifo_empty;
  // A read in the strobe cycle itself lands in READY and is therefore a violation.
  assign proto_set    = (ep_read & ~in_xfer) | (ep_blockstrobe & (state != S_READY));

  // Reads during underrun still count toward the block so host framing is preserved.
  assign fifo_rd_en = in_xfer & ep_read & ~fifo_empty;
  assign ep_datain  = fifo_empty ? 16'h0000 : fifo_dout;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    idle_cnt_nxt = idle_cnt;
    unique case (state)
      S_IDLE: begin
        if (fifo_rd_ready) state_nxt = S_READY;
      end
      S_READY: begin
        if (ep_blockstrobe) begin
          state_nxt    = S_XFER;
          word_cnt_nxt = '0;
          idle_cnt_nxt = '0;
        end
      end
      S_XFER: begin
        if (ep_read) begin
          word_cnt_nxt = word_cnt + CNT_W'(1);
          idle_cnt_nxt = '0;
          if (last_word) state_nxt = S_DONE;
        end else if (stall_limit) begin
          state_nxt = S_DONE;
        end else begin
          idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Offered only while READY persists, so ep_ready never lingers into XFER.
  assign ep_ready_nxt = (state == S_READY) & (state_nxt == S_READY);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      ep_ready    <= 1'b0;
      block_count <= '0;
      underrun    <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      word_cnt    <= word_cnt_nxt;
      idle_cnt    <= idle_cnt_nxt;
      ep_ready    <= ep_ready_nxt;
      block_count <= block_count + 16'(block_done);
      // Set wins over a coincident clear.
      underrun    <= underrun_set | (underrun    & ~err_clr);
      timeout_err <= timeout_set  | (timeout_err & ~err_clr);
      proto_err   <= proto_set    | (proto_err   & ~err_clr);
    end
  end

endmodule

// File: tb/tb_pipe_out_block_ctrl.sv
// Self-checking bench for pipe_out_block_ctrl: randomized host/FIFO stimulus checked
// against expectations derived from block-transfer rules.
module tb_pipe_out_block_ctrl;

  localparam int BLOCK_LEN = 1024;
  localparam int TIMEOUT   = 16;

  logic        rd_clk = 1'b0;
  logic        rst;
  logic        fifo_rd_ready;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        ep_ready;
  logic        ep_blockstrobe;
  logic        ep_read;
  logic [15:0] ep_datain;
  logic        err_clr;
  logic [15:0] block_count;
  logic        underrun;
  logic        timeout_err;
  logic        proto_err;

  int n_cmp = 0;
  int n_err = 0;
  int m_blocks = 0;

  pipe_out_block_ctrl #(
    .BLOCK_LEN(BLOCK_LEN),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (11)
  ) dut (
    .rd_clk        (rd_clk),
    .rst           (rst),
    .fifo_rd_ready (fifo_rd_ready),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout),
    .fifo_rd_en    (fifo_rd_en),
    .ep_ready      (ep_ready),
    .ep_blockstrobe(ep_blockstrobe),
    .ep_read       (ep_read),
    .ep_datain     (ep_datain),
    .err_clr       (err_clr),
    .block_count   (block_count),
    .underrun      (underrun),
    .timeout_err   (timeout_err),
    .proto_err     (proto_err)
  );

  always #5 rd_clk = ~rd_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
  endtask

  task automatic check_flags(input string tag, input bit u, input bit t, input bit p);
    check({tag, "_underrun"}, underrun, u);
    check({tag, "_timeout"},  timeout_err, t);
    check({tag, "_proto"},    proto_err, p);
  endtask

  task automatic wait_ready();
    bit seen = 0;
    fifo_rd_ready = 1'b1;
    fifo_empty    = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      next_cycle();
      seen = ep_ready;
    end
    if (!seen) check("ready_wait", ep_ready, 1'b1);
  endtask

  // Strobe a block, then issue n host reads. Reads in [ur_lo, ur_hi] see an empty FIFO.
  task automatic run_block(input int n, input int ur_lo, input int ur_hi,
                           input bit seq_data, input bit gaps, input bit strobe_read);
    int pulses = 0;
    int exp_pulses = 0;
    logic [15:0] d;
    ep_blockstrobe = 1'b1;
    ep_read        = strobe_read;
    fifo_rd_ready  = 1'b0;
    fifo_empty     = 1'b0;
    @(negedge rd_clk);
    check("strobe_rd_en", fifo_rd_en, 1'b0);
    next_cycle();
    ep_blockstrobe = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ep_read    = 1'b0;
          fifo_dout  = 16'($urandom);
          fifo_empty = 1'($urandom_range(0, 1));
          @(negedge rd_clk);
          check("gap_rd_en", fifo_rd_en, 1'b0);
          check("gap_datain", ep_datain, fifo_empty ? 16'h0000 : fifo_dout);
          next_cycle();
        end
      end
      d          = seq_data ? 16'(i) : 16'($urandom);
      ep_read    = 1'b1;
      fifo_dout  = d;
      fifo_empty = (i >= ur_lo) && (i <= ur_hi);
      @(negedge rd_clk);
      check("datain", ep_datain, fifo_empty ? 16'h0000 : d);
      check("rd_en", fifo_rd_en, !fifo_empty);
      check("ready_in_xfer", ep_ready, 1'b0);
      if (fifo_rd_en) pulses++;
      if (!fifo_empty) exp_pulses++;
      next_cycle();
    end
    ep_read    = 1'b0;
    fifo_empty = 1'b0;
    check("rd_en_pulses", pulses, exp_pulses);
    if (n == BLOCK_LEN) begin
      m_blocks++;
      fifo_rd_ready = 1'b1;
      @(negedge rd_clk);
      check("ready_low_post1", ep_ready, 1'b0);
      check("block_count", block_count, 16'(m_blocks));
      next_cycle();
      @(negedge rd_clk);
      check("ready_low_post2", ep_ready, 1'b0);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    fifo_rd_ready = 0; fifo_empty = 0; fifo_dout = 0;
    ep_blockstrobe = 0; ep_read = 0; err_clr = 0;

    // Reset with random inputs
    repeat (3) begin
      fifo_rd_ready  = 1'($urandom);
      fifo_empty     = 1'($urandom);
      fifo_dout      = 16'($urandom);
      ep_blockstrobe = 1'($urandom);
      ep_read        = 1'($urandom);
      err_clr        = 1'($urandom);
      next_cycle();
    end
    check("rst_ep_ready", ep_ready, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_block_count", block_count, 16'd0);
    check_flags("rst", 0, 0, 0);
    rst = 1'b0;
    fifo_rd_ready = 0; fifo_empty = 0; ep_blockstrobe = 0; ep_read = 0; err_clr = 0;
    next_cycle();
    next_cycle();
    check("idle_ep_ready", ep_ready, 1'b0);

    // Normal block with sequential data; ep_ready one cycle after READY entry
    fifo_rd_ready = 1'b1;
    next_cycle();
    check("ready_entry", ep_ready, 1'b0);
    next_cycle();
    check("ready_rise", ep_ready, 1'b1);
    run_block(BLOCK_LEN, -1, -1, 1, 0, 0);
    check_flags("normal", 0, 0, 0);

    // Underrun on reads 500..502
    wait_ready();
    run_block(BLOCK_LEN, 500, 502, 0, 0, 0);
    check_flags("underrun_blk", 1, 0, 0);
    pulse_clr();
    check_flags("underrun_clr", 0, 0, 0);

    // Random data and read gaps; second block also reads in the strobe cycle
    for (int b = 0; b < 2; b++) begin
      wait_ready();
      run_block(BLOCK_LEN, -1, -1, 0, 1, 1'(b));
      check_flags("rand_blk", 0, 0, 1'(b));
      pulse_clr();
    end

    // Host stalls after 10 reads
    wait_ready();
    run_block(10, -1, -1, 0, 0, 0);
    repeat (TIMEOUT - 1) @(posedge rd_clk);
    #1;
    check("timeout_early", timeout_err, 1'b0);
    next_cycle();
    check("timeout_set", timeout_err, 1'b1);
    check("timeout_block_count", block_count, 16'(m_blocks));
    next_cycle();
    next_cycle();

    // Back in IDLE: a read is a violation and must not pop the FIFO
    ep_read = 1'b1;
    fifo_empty = 1'b0;
    @(negedge rd_clk);
    check("idle_read_rd_en", fifo_rd_en, 1'b0);
    next_cycle();
    ep_read = 1'b0;
    check_flags("idle_read", 0, 1, 1);
    pulse_clr();
    check_flags("clear", 0, 0, 0);
    err_clr = 1'b1;
    ep_blockstrobe = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    ep_blockstrobe = 1'b0;
    check_flags("set_beats_clr", 0, 0, 1);
    pulse_clr();

    // Reset at word 300 of a block
    wait_ready();
    run_block(300, -1, -1, 0, 1, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_blocks = 0;
    check("midrst_ep_ready", ep_ready, 1'b0);
    check("midrst_block_count", block_count, 16'd0);
    ep_read = 1'b1;
    @(negedge rd_clk);
    check("midrst_rd_en", fifo_rd_en, 1'b0);
    next_cycle();
    ep_read = 1'b0;
    check("midrst_proto", proto_err, 1'b1);
    pulse_clr();
    wait_ready();
    run_block(BLOCK_LEN, -1, -1, 0, 1, 0);
    check_flags("final", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_out_block_ctrl.md
Name: pipe_out_block_ctrl

Overview:
- Downstream neighbour of the pipe TX FIFO, in the rd_clk (host interface) domain.
- Bridges the FIFO's block-ready indication and first-word-fall-through data to the host block-throttled pipe-out endpoint (ready / blockstrobe / read / datain).
- Enforces exact BLOCK_LEN-word transfers, so the FIFO's own read counter stays aligned with host blocks.
- Detects underrun, host stall (timeout) and protocol violations, and counts completed blocks for status readback.

Parameters:
- BLOCK_LEN, 1024, words per host block; must equal the FIFO-side block read length.
- TIMEOUT, 65535, rd_clk cycles without ep_read inside a block before the block is aborted.
- CNT_W, 11, width of the word counter; must satisfy 2^CNT_W > BLOCK_LEN.

Ports:
- rd_clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_ready  in  1  FIFO holds at least one full block.
- fifo_empty  in  1  FIFO empty.
- fifo_dout  in  16  FIFO first-word-fall-through head word.
- fifo_rd_en  out  1  pops the FIFO head word; combinational.
- ep_ready  out  1  to host endpoint: block available; registered.
- ep_blockstrobe  in  1  host starts a block.
- ep_read  in  1  host takes one word this cycle.
- ep_datain  out  16  word presented to host; combinational.
- err_clr  in  1  single-cycle pulse; clears all sticky flags.
- block_count  out  16  completed blocks; wraps at 16'hFFFF -> 0.
- underrun  out  1  sticky flag.
- timeout_err  out  1  sticky flag.
- proto_err  out  1  sticky flag.

Behaviour:
- Reset: state IDLE; word_cnt = 0; idle_cnt = 0; ep_ready = 0; block_count = 0; all sticky flags = 0; fifo_rd_en = 0.
- rst overrides everything, including mid-block. No partial-block recovery: the FIFO shares rst.
- States:
  - IDLE: ep_ready = 0. fifo_rd_ready = 1 -> READY.
  - READY: ep_ready = 1 (registered, so it rises the cycle after READY is entered). ep_blockstrobe = 1 -> XFER; word_cnt <= 0, idle_cnt <= 0.
  - XFER: ep_ready = 0.
    - Each cycle with ep_read = 1: word_cnt++, idle_cnt <= 0.
    - ep_read with word_cnt == BLOCK_LEN-1 -> DONE; block_count++.
    - Each cycle without ep_read: idle_cnt++. idle_cnt == TIMEOUT-1 -> timeout_err <= 1, go to DONE, block_count unchanged.
  - DONE: exactly one cycle, ep_ready = 0, then -> IDLE. This guarantees ep_ready stays low for at least 2 cycles after the last read.
- Data path:
  - fifo_rd_en = (state == XFER) & ep_read & ~fifo_empty.
  - ep_datain = fifo_empty ? 16'h0000 : fifo_dout. Zero latency; the word is valid in the same cycle as ep_read.
- Underrun: ep_read in XFER while fifo_empty = 1 sets underrun <= 1 and suppresses fifo_rd_en. word_cnt still advances, so the host block length is preserved.
- Protocol errors, each setting proto_err <= 1:
  - ep_read outside XFER; fifo_rd_en stays 0.
  - ep_blockstrobe in IDLE, XFER or DONE; the strobe is otherwise ignored.
- ep_blockstrobe and ep_read in the same READY cycle: the read is a protocol error and is not counted; XFER is still entered.
- Sticky flags:
  - Set has priority over err_clr in the same cycle.
  - err_clr does not affect state, word_cnt or block_count.
- fifo_rd_ready dropping while in READY: stay in READY. The FIFO guarantees the block remains buffered.

Test Plan:
- Reset: rst high for 3 cycles with random inputs -> ep_ready = 0, fifo_rd_en = 0, block_count = 0, all flags 0.
- Normal block: fifo_rd_ready = 1 -> ep_ready = 1 one cycle after READY is entered. Then strobe, then 1024 back-to-back ep_read with fifo_dout = 0..1023 -> ep_datain matches each word, exactly 1024 fifo_rd_en pulses, block_count = 1, ep_ready low for ≥2 cycles after the last read, no flags.
- Underrun: fifo_empty = 1 during reads 500-502 -> ep_datain = 0 and fifo_rd_en = 0 on those 3 reads, underrun = 1, block still ends after 1024 ep_reads, block_count = 1.
- Timeout (TIMEOUT = 16): host stops after 10 reads -> timeout_err = 1 sixteen cycles after the last read, state returns to IDLE, block_count = 0.
- Protocol + clear: ep_read in IDLE -> proto_err = 1, fifo_rd_en = 0. Then err_clr pulse -> proto_err = 0. Then err_clr coincident with a new violation -> proto_err stays 1.
- Reset mid-block: rst at word 300 of a block -> IDLE next cycle, ep_ready = 0, block_count = 0. A following full block completes normally with block_count = 1.
